program_loader: RTL



---
 rtl/program_loader_pkg.sv | 19 +
 rtl/program_loader_word_assembler.sv | 39 +++
 rtl/program_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants and FSM encoding for the program loader.
// The LOADER_CHECKSUM_EN build uses the extra CHECK state.
package program_loader_pkg;

    localparam int DEF_NB_INSTRUC = 32;
    localparam int DEF_NB_BYTE    = 8;
    localparam int BYTES_PER_WORD = DEF_NB_INSTRUC / DEF_NB_BYTE;
    localparam logic [DEF_NB_INSTRUC-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4,
        ST_CHECK = 3'd5
    } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects bytes MSB-first into a word; pulses word_ready alongside the last byte.
module program_loader_word_assembler
    import program_loader_pkg::*;
#(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               byte_valid,
    input  logic [NB_BYTE-1:0] byte_in,
    output logic [NB_WORD-1:0] word,
    output logic               word_ready
);

    localparam logic [1:0] LAST_CNT = 2'(BYTES_PER_WORD - 1);

    // Only the leading bytes need storage; the last one is taken straight from byte_in.
    logic [NB_WORD-NB_BYTE-1:0] shift_r;
    logic [1:0]                 cnt_r;

    assign word       = {shift_r, byte_in};
    assign word_ready = byte_valid && (cnt_r == LAST_CNT);

    // Byte counter and shift register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_r   <= 2'd0;
            shift_r <= '0;
        end else if (byte_valid) begin
            cnt_r   <= cnt_r + 2'd1;
            shift_r <= {shift_r[NB_WORD-2*NB_BYTE-1:0], byte_in};
        end else begin
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: assembles UART bytes into instruction words and writes them
// to program memory, stalling the pipeline until the HALT word is stored.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte, o_chk_err).
module program_loader
    import program_loader_pkg::*;
#(
    parameter int NB_INSTRUC        = DEF_NB_INSTRUC,
    parameter int NB_ADDR           = 32,
    parameter int NB_BYTE           = DEF_NB_BYTE,
    parameter int RAM_DEPTH_PROGRAM = 2048,
    parameter logic [NB_INSTRUC-1:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NB_BYTE-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    output logic                  o_wr_en,
    output logic [NB_ADDR-1:0]    o_wr_addr,
    output logic [NB_INSTRUC-1:0] o_wr_data,
    output logic                  o_pipe_stall,
    output logic                  o_load_done,
`ifdef LOADER_CHECKSUM_EN
    output logic                  o_overflow,
    output logic                  o_chk_err
`else
    output logic                  o_overflow
`endif
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH_PROGRAM - 1);

    state_t state_r, next_state_s;

    logic                  next_wr_en_s;
    logic [NB_ADDR-1:0]    next_addr_s;
    logic [NB_INSTRUC-1:0] next_data_s;
    logic                  next_stall_s;
    logic                  next_done_s;
    logic                  next_ovf_s;
    logic                  start_acc_s;
    logic                  asm_en_s;
    logic                  asm_clr_n_s;
    logic [NB_INSTRUC-1:0] asm_word_s;
    logic                  asm_ready_s;
`ifdef LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0]    chk_acc_r, next_chk_acc_s;
    logic                  next_chk_err_s;
`endif

    // A new load discards any partially assembled word.
    assign asm_clr_n_s = i_rst && !start_acc_s;

    program_loader_word_assembler #(
        .NB_WORD (NB_INSTRUC),
        .NB_BYTE (NB_BYTE)
    ) u_asm (
        .clk        (i_clk),
        .clr_n      (asm_clr_n_s),
        .byte_valid (i_rx_done && asm_en_s),
        .byte_in    (i_rx_data),
        .word       (asm_word_s),
        .word_ready (asm_ready_s)
    );

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        next_state_s = state_r;
        next_wr_en_s = 1'b0;
        next_addr_s  = o_wr_addr;
        next_data_s  = o_wr_data;
        next_stall_s = o_pipe_stall;
        next_done_s  = o_load_done;
        next_ovf_s   = o_overflow;
        start_acc_s  = 1'b0;
        asm_en_s     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        next_chk_err_s = o_chk_err;
        next_chk_acc_s = chk_acc_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    start_acc_s  = 1'b1;
                    next_state_s = ST_RECV;
                    next_addr_s  = '0;
                    next_stall_s = 1'b1;
                    next_done_s  = 1'b0;
                    next_ovf_s   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    next_chk_err_s = 1'b0;
`endif
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RECV: begin
                asm_en_s = 1'b1;
                if (asm_ready_s) begin
                    next_state_s = ST_WRITE;
                    next_wr_en_s = 1'b1;
                    next_data_s  = asm_word_s;
                end else begin
                    next_state_s = ST_RECV;
                end
            end
            ST_WRITE: begin
                // A strobe here is already byte 0 of the next word.
                asm_en_s = 1'b1;
                if (o_wr_data == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state_s = ST_CHECK;
`else
                    next_state_s = ST_DONE;
                    next_stall_s = 1'b0;
                    next_done_s  = 1'b1;
`endif
                end else if (o_wr_addr == LAST_ADDR) begin
                    next_state_s = ST_ERROR;
                    next_ovf_s   = 1'b1;
                end else begin
                    next_state_s = ST_RECV;
                    next_addr_s  = o_wr_addr + NB_ADDR'(1);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_rx_done) begin
                    if (i_rx_data == chk_acc_r) begin
                        next_state_s = ST_DONE;
                        next_stall_s = 1'b0;
                        next_done_s  = 1'b1;
                    end else begin
                        next_state_s   = ST_ERROR;
                        next_chk_err_s = 1'b1;
                    end
                end else begin
                    next_state_s = ST_CHECK;
                end
            end
`endif
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
`ifdef LOADER_CHECKSUM_EN
        // Checksum covers every data byte taken since the last start.
        if (start_acc_s) begin
            next_chk_acc_s = '0;
        end else if (asm_en_s && i_rx_done) begin
            next_chk_acc_s = chk_acc_r ^ i_rx_data;
        end else begin
            next_chk_acc_s = chk_acc_r;
        end
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r      <= ST_IDLE;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_pipe_stall <= 1'b0;
            o_load_done  <= 1'b0;
            o_overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            o_chk_err    <= 1'b0;
            chk_acc_r    <= '0;
`endif
        end else begin
            state_r      <= next_state_s;
            o_wr_en      <= next_wr_en_s;
            o_wr_addr    <= next_addr_s;
            o_wr_data    <= next_data_s;
            o_pipe_stall <= next_stall_s;
            o_load_done  <= next_done_s;
            o_overflow   <= next_ovf_s;
`ifdef LOADER_CHECKSUM_EN
            o_chk_err    <= next_chk_err_s;
            chk_acc_r    <= next_chk_acc_s;
`endif
        end
    end

endmodule
